avalon_button_pio: RTL and testbench
====================================

// Module: avalon_button_pio
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons and switches. It is the successor to the 2-bit read-only button port.
//  - Synchronises and debounces WIDTH inputs.
//  - Captures press/release edges and raises a maskable interrupt to the Nios II.
//  - Sits on the system interconnect as a 4-word slave.
// PARAMETERS
//  WIDTH            2     number of input channels (1..32)
//  DEBOUNCE_CYCLES  4     consecutive stable cycles needed to accept a new level; 0 = debounce bypassed
//  EDGE_TYPE        1     capture edge: 0 rising, 1 falling (press on active-low keys), 2 any
//  RESET_VALUE      '1    reset level of the synchroniser and debounced state (WIDTH bits, default all ones)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  chipselect  in   1      slave select
//  address     in   2      word address
//  write       in   1      write strobe (qualified by chipselect)
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous button inputs
//  readdata    out  32     registered read data, zero-extended
//  irq         out  1      registered interrupt request, level
// BEHAVIOUR
//  Register map (word address):
//   - 0 DATA: debounced level, read-only.
//   - 1 RAW: synchronised undebounced level, read-only.
//   - 2 IRQMASK: read/write, WIDTH bits.
//   - 3 EDGECAPTURE: read; a write of 1 clears the corresponding bit (write-1-to-clear).
//  Read path: readdata <= zero-extend(mux[address]) on every clk; valid 1 cycle after address is presented. No wait states.
//  Synchroniser: 2 flops per channel, reset to RESET_VALUE.
//  Debounce (per channel): counter width $clog2(DEBOUNCE_CYCLES+1).
//   - If sync == stable, the counter is cleared.
//   - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the next edge loads stable <= sync and clears the counter.
//   - Latency from in_port change to DATA change is 2 + DEBOUNCE_CYCLES clocks.
//   - A glitch shorter than DEBOUNCE_CYCLES clocks never reaches DATA.
//   - If DEBOUNCE_CYCLES == 0, stable <= sync every cycle.
//  Edge detect: stable_d is stable delayed 1 cycle.
//   - EDGE_TYPE 0: edge = stable & ~stable_d.
//   - EDGE_TYPE 1: edge = ~stable & stable_d.
//   - EDGE_TYPE 2: edge = stable ^ stable_d.
//   - The EDGECAPTURE bit sets on the clock after stable changes and is sticky.
//  Simultaneous clear-write and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
//  irq <= |(EDGECAPTURE & IRQMASK); it asserts 1 cycle after the bit or mask becomes nonzero and deasserts 1 cycle after clear.
//  Writes to addresses 0/1 are ignored. Writes without chipselect are ignored. Bits above WIDTH read 0 and ignore writes.
//  Reset values:
//   - readdata 0, irq 0, IRQMASK 0, EDGECAPTURE 0, counters 0.
//   - sync, stable and stable_d are RESET_VALUE, so no spurious edge appears after reset.
//  Reset asserted mid-debounce aborts the count. No edge is recorded for a level that was still being qualified.
// CONFIGURATION
//  BUTTON_PIO_IRQ_EN defined:
//   - IRQMASK register and irq logic are present as above.
//  BUTTON_PIO_IRQ_EN undefined:
//   - irq is tied 0.
//   - IRQMASK reads 0 and ignores writes.
//   - EDGECAPTURE is still captured, so the block is polled.
// TESTING (WIDTH=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, macro defined)
//  1. Release reset, read addr 0 -> readdata 0x3; addr 3 -> 0x0; irq 0 throughout.
//  2. in_port=2'b10 for 3 clks then back to 2'b11 -> DATA stays 0x3, RAW shows 0x2 transiently, EDGECAPTURE 0x0.
//  3. in_port=2'b10 held -> DATA reads 0x2 exactly 6 clks after the change; EDGECAPTURE reads 0x1 one clk later.
//  4. Write IRQMASK=0x1 with EDGECAPTURE=0x1 -> irq=1 next clk; write EDGECAPTURE=0x1 -> bit clears, irq=0 next clk.
//  5. Write-1 clear to bit 1 in the same clk that bit 1's falling edge is detected -> EDGECAPTURE bit 1 remains 1.
//  6. Assert reset 2 clks into qualifying in_port=2'b01 -> all regs at reset values; after release with input held, DATA reaches 0x1 after a full 6 clks.

Source files
------------

// File: rtl/avalon_button_pio_if.sv
// -----------------------------------------------------------------------------
// avalon_button_pio_if
// Avalon-MM slave bus bundle for the button/switch PIO.
//   chipselect  master->slave  slave select
//   address     master->slave  2-bit word address
//   write       master->slave  write strobe, qualified by chipselect
//   writedata   master->slave  32-bit write data
//   readdata    slave->master  32-bit registered read data
//   irq         slave->master  level interrupt request
// -----------------------------------------------------------------------------
interface avalon_button_pio_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output chipselect, address, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/avalon_button_pio.sv
// -----------------------------------------------------------------------------
// avalon_button_pio
// Parametrised Avalon-MM input PIO for push-buttons and switches. Each input
// is synchronised, debounced and edge-detected; captured edges are sticky and
// can raise a maskable level interrupt.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   bus      avalon_button_pio_if.slave (chipselect, address, write,
//            writedata, readdata, irq)
//   in_port  WIDTH raw asynchronous button inputs
//
// Register map (word address):
//   0 DATA         debounced level (read-only)
//   1 RAW          synchronised, undebounced level (read-only)
//   2 IRQMASK      interrupt mask (read/write)
//   3 EDGECAPTURE  sticky captured edges (write 1 to clear)
//
// Configuration macro: BUTTON_PIO_IRQ_EN
//   defined   -> IRQMASK register and irq logic present
//   undefined -> irq tied 0, IRQMASK reads 0; EDGECAPTURE still captured
// -----------------------------------------------------------------------------
module avalon_button_pio #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_button_pio_if.slave     bus,
  input  logic [WIDTH-1:0]       in_port
);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      read_mux;
  logic [31:0]      readdata_q;
  logic             irq_q;
  logic             bus_write;

  // Upper writedata bits beyond WIDTH are intentionally ignored.
  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

  assign bus_write = bus.chipselect & bus.write;

  // Two-flop synchroniser; reset to RESET_VALUE so that idle (released)
  // buttons do not look like a transition coming out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= RESET_VALUE;
      sync_q    <= RESET_VALUE;
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
    end
  end

  // Debounce: a channel only adopts a new level after it has differed from
  // the accepted level for DEBOUNCE_CYCLES consecutive clocks. Any return to
  // the accepted level restarts the qualification.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stable <= RESET_VALUE;
        else       stable <= sync_q;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt [WIDTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable <= RESET_VALUE;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              stable[i] <= sync_q[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_d <= RESET_VALUE;
    else       stable_d <= stable;
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = stable & ~stable_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~stable & stable_d;
    end else begin : g_any
      assign edge_det = stable ^ stable_d;
    end
  endgenerate

  assign edge_clear = (bus_write && bus.address == 2'd3) ?
                      bus.writedata[WIDTH-1:0] : '0;

  // Sticky edge capture. A new edge in the same cycle as a clear wins, so an
  // event arriving while software acknowledges an older one is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) edge_capture <= '0;
    else       edge_capture <= (edge_capture & ~edge_clear) | edge_det;
  end

`ifdef BUTTON_PIO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (bus_write && bus.address == 2'd2) begin
      irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(edge_capture & irq_mask);
  end
`else
  // Polled-only build: no mask storage and no interrupt.
  assign irq_mask = '0;
  assign irq_q    = 1'b0;
`endif

  // Read mux, zero-extended to the 32-bit bus.
  always_comb begin
    read_mux = '0;
    case (bus.address)
      2'd0:    read_mux[WIDTH-1:0] = stable;
      2'd1:    read_mux[WIDTH-1:0] = sync_q;
      2'd2:    read_mux[WIDTH-1:0] = irq_mask;
      default: read_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // Registered read data: valid one clock after the address is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= read_mux;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_avalon_button_pio.sv
// -----------------------------------------------------------------------------
// tb_avalon_button_pio
// Directed self-checking bench for avalon_button_pio with WIDTH=2,
// DEBOUNCE_CYCLES=4, EDGE_TYPE=1 (falling). Expected values for the mask and
// interrupt follow whether BUTTON_PIO_IRQ_EN is defined for this build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_avalon_button_pio;

`ifdef BUTTON_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in_port;
  int         tests_run    = 0;
  int         tests_failed = 0;

  avalon_button_pio_if bus ();

  avalon_button_pio #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(2'b11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .in_port(in_port)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_readdata: got %0h expected 0", bus.readdata);
    end
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_irq: got %0b expected 0", bus.irq);
    end
    reset = 1'b0;
    bus.address = 2'd0;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h3) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %0h expected 3", bus.readdata);
    end
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_edgecap: got %0h expected 0", bus.readdata);
    end
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_irq_after: got %0b expected 0", bus.irq);
    end
  endtask

  task automatic test_glitch();
    bus.address = 2'd1;
    in_port = 2'b10;
    tick(3);
    tests_run++;
    if (bus.readdata !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL glitch_raw: got %0h expected 2", bus.readdata);
    end
    in_port = 2'b11;
    tick(6);
    bus.address = 2'd0;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h3) begin
      tests_failed++;
      $display("[TB] FAIL glitch_data: got %0h expected 3", bus.readdata);
    end
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_edgecap: got %0h expected 0", bus.readdata);
    end
  endtask

  task automatic test_debounce_latency();
    bus.address = 2'd0;
    in_port = 2'b10;
    tick(5);
    tests_run++;
    if (bus.readdata !== 32'h3) begin
      tests_failed++;
      $display("[TB] FAIL latency_early: got %0h expected 3", bus.readdata);
    end
    tick(2);
    tests_run++;
    if (bus.readdata !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL latency_data: got %0h expected 2", bus.readdata);
    end
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL latency_edgecap: got %0h expected 1", bus.readdata);
    end
  endtask

  task automatic test_irq();
    bus_write(2'd2, 32'h1);
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_same_cycle: got %0b expected 0", bus.irq);
    end
    tick(1);
    tests_run++;
    if (bus.irq !== IRQ_EN) begin
      tests_failed++;
      $display("[TB] FAIL irq_assert: got %0b expected %0b", bus.irq, IRQ_EN);
    end
    bus_write(2'd3, 32'h1);
    tests_run++;
    if (bus.irq !== IRQ_EN) begin
      tests_failed++;
      $display("[TB] FAIL irq_hold: got %0b expected %0b", bus.irq, IRQ_EN);
    end
    tick(1);
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_deassert: got %0b expected 0", bus.irq);
    end
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL irq_edgecap_clear: got %0h expected 0", bus.readdata);
    end
    bus.address = 2'd2;
    tick(1);
    tests_run++;
    if (bus.readdata !== (IRQ_EN ? 32'h1 : 32'h0)) begin
      tests_failed++;
      $display("[TB] FAIL irq_mask_read: got %0h expected %0h",
               bus.readdata, (IRQ_EN ? 32'h1 : 32'h0));
    end
  endtask

  task automatic test_set_wins();
    in_port = 2'b00;
    tick(6);
    bus_write(2'd3, 32'h2);
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL set_wins_edgecap: got %0h expected 2", bus.readdata);
    end
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL set_wins_irq_masked: got %0b expected 0", bus.irq);
    end
    bus_write(2'd3, 32'h2);
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL set_wins_later_clear: got %0h expected 0", bus.readdata);
    end
  endtask

  task automatic test_register_access();
    bus.chipselect = 1'b0;
    bus.write      = 1'b1;
    bus.address    = 2'd2;
    bus.writedata  = 32'h0;
    tick(1);
    bus.write = 1'b0;
    tick(1);
    tests_run++;
    if (bus.readdata !== (IRQ_EN ? 32'h1 : 32'h0)) begin
      tests_failed++;
      $display("[TB] FAIL regs_no_chipselect: got %0h expected %0h",
               bus.readdata, (IRQ_EN ? 32'h1 : 32'h0));
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    tick(1);
    tests_run++;
    if (bus.readdata !== (IRQ_EN ? 32'h3 : 32'h0)) begin
      tests_failed++;
      $display("[TB] FAIL regs_mask_width: got %0h expected %0h",
               bus.readdata, (IRQ_EN ? 32'h3 : 32'h0));
    end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus.address = 2'd0;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL regs_data_readonly: got %0h expected 0", bus.readdata);
    end
  endtask

  task automatic test_reset_mid_debounce();
    bus.address = 2'd0;
    in_port = 2'b01;
    tick(2);
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got rd=%0h irq=%0b expected rd=0 irq=0",
               bus.readdata, bus.irq);
    end
    tick(2);
    bus.address = 2'd3;
    reset = 1'b0;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_edgecap: got %0h expected 0", bus.readdata);
    end
    bus.address = 2'd0;
    tick(4);
    tests_run++;
    if (bus.readdata !== 32'h3) begin
      tests_failed++;
      $display("[TB] FAIL midreset_data_early: got %0h expected 3", bus.readdata);
    end
    tick(2);
    tests_run++;
    if (bus.readdata !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_data: got %0h expected 1", bus.readdata);
    end
    bus.address = 2'd3;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL midreset_new_edge: got %0h expected 2", bus.readdata);
    end
    tests_run++;
    if (bus.irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_irq: got %0b expected 0", bus.irq);
    end
    bus.address = 2'd2;
    tick(1);
    tests_run++;
    if (bus.readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_mask: got %0h expected 0", bus.readdata);
    end
  endtask

  initial begin
    reset          = 1'b1;
    in_port        = 2'b11;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    test_reset();
    test_glitch();
    test_debounce_latency();
    test_irq();
    test_set_wins();
    test_register_access();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
